// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// ---------------
// Forwarding and load-use hazard unit for the in-order pipeline. It keeps a
// shift pipeline of NSTAGE in-flight destination records (stage 1 = EX,
// stage NSTAGE = oldest). From those records it produces an operand-mux select
// for each decode read port and a load-use stall. It also keeps a saturating
// count of stalled cycles.
//
// Ports:
//   clk            pipeline clock, all state on the rising edge
//   rst            asynchronous active-high reset
//   issue_valid    decode holds a valid instruction
//   issue_we       that instruction writes a register
//   issue_widx     its destination index
//   issue_is_load  that instruction is a load
//   rd_en          per-port read enable
//   rd_idx         per-port read index, port p at [p*IDX_W +: IDX_W]
//   flush          kill all tracked entries and drop the issuing instruction
//   mux_sel        per-port select: 1 = register file, k+1 = stage k result
//   stall_out      load-use hazard, decode must hold
//   stall_cnt      saturating count of cycles with stall_out high
module fwd_hazard_unit #(
    parameter int IDX_W       = 4,
    parameter int NREAD       = 2,
    parameter int NSTAGE      = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int SEL_W       = $clog2(NSTAGE + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [IDX_W-1:0]         issue_widx,
    input  logic                     issue_is_load,
    input  logic [NREAD-1:0]         rd_en,
    input  logic [NREAD*IDX_W-1:0]   rd_idx,
    input  logic                     flush,
    output logic [NREAD*SEL_W-1:0]   mux_sel,
    output logic                     stall_out,
    output logic [15:0]              stall_cnt
);

    // Tracked entries; array index k holds pipeline stage k+1.
    logic [NSTAGE-1:0] st_valid;
    logic [NSTAGE-1:0] st_we;
    logic [NSTAGE-1:0] st_load;
    logic [IDX_W-1:0]  st_widx [NSTAGE];

    logic [NREAD-1:0]  port_hazard;

    // ------------------------------------------------------------------
    // Per-port select and hazard lookup
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [IDX_W-1:0] idx;
        logic             zero_block;
        logic             found;
        logic             hazard;
        logic [SEL_W-1:0] sel;

        assign idx        = rd_idx[p*IDX_W +: IDX_W];
        assign zero_block = (ZERO_REG_EN != 0) && (idx == '0);

        // NOTE: every signal gets a default at the top of the block so no
        // path leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            found  = 1'b0;
            hazard = 1'b0;
            sel    = SEL_W'(1);
            // Scanning from the youngest stage and freezing on the first hit
            // makes a younger writer shadow an older one with the same index.
            for (int k = 0; k < NSTAGE; k++) begin
                if (!found && rd_en[p] && !zero_block &&
                    st_valid[k] && st_we[k] && (st_widx[k] == idx)) begin
                    found = 1'b1;
                    // Load data is not ready until stage LOAD_LAT+1; until
                    // then the port reads the register file and decode holds.
                    if (st_load[k] && (k < LOAD_LAT)) begin
                        hazard = 1'b1;
                    end else begin
                        sel = SEL_W'(k + 2);
                    end
                end
            end
        end

        assign port_hazard[p]               = hazard;
        assign mux_sel[p*SEL_W +: SEL_W]    = sel;
    end

    // A flush discards the stalled consumer anyway, so it wins over a stall.
    assign stall_out = (|port_hazard) && !flush;

    // ------------------------------------------------------------------
    // Entry pipeline: valid bits and the stall counter are reset
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour and the shift stays ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid  <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                st_valid <= '0;
            end else begin
                for (int k = NSTAGE - 1; k >= 1; k--) begin
                    st_valid[k] <= st_valid[k-1];
                end
                // A stalled cycle inserts a bubble into stage 1.
                st_valid[0] <= issue_valid && !stall_out;
            end

            if (stall_out && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // NOTE: the payload fields are deliberately not reset; they are only
    // looked at while the matching valid bit is set, and valid is reset.
    always_ff @(posedge clk) begin
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            st_we[k]   <= st_we[k-1];
            st_load[k] <= st_load[k-1];
            st_widx[k] <= st_widx[k-1];
        end
        st_we[0]   <= issue_we;
        st_load[0] <= issue_is_load;
        st_widx[0] <= issue_widx;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit. Three configurations share one stimulus
// stream:
//   a: defaults (NSTAGE=2, LOAD_LAT=1, ZERO_REG_EN=0)
//   b: NSTAGE=3, LOAD_LAT=2, ZERO_REG_EN=1
//   c: NSTAGE=6, LOAD_LAT=5, which keeps the stall asserted 5 cycles in 6
//      so the counter saturates quickly
// The reference model keeps a history of accepted instructions tagged with
// their issue cycle. A record is visible at stage (now - issue_cycle) unless a
// flush or reset happened at or after its issue cycle.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_we, issue_is_load, flush;
    logic [3:0] issue_widx;
    logic [1:0] rd_en;
    logic [7:0] rd_idx;

    logic [3:0]  sel_a;
    logic [5:0]  sel_b, sel_c;
    logic        stall_a, stall_b, stall_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.IDX_W(4), .NREAD(2), .NSTAGE(2), .LOAD_LAT(1), .ZERO_REG_EN(0)) u_a (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_widx(issue_widx), .issue_is_load(issue_is_load), .rd_en(rd_en),
        .rd_idx(rd_idx), .flush(flush), .mux_sel(sel_a), .stall_out(stall_a),
        .stall_cnt(cnt_a));

    fwd_hazard_unit #(.IDX_W(4), .NREAD(2), .NSTAGE(3), .LOAD_LAT(2), .ZERO_REG_EN(1)) u_b (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_widx(issue_widx), .issue_is_load(issue_is_load), .rd_en(rd_en),
        .rd_idx(rd_idx), .flush(flush), .mux_sel(sel_b), .stall_out(stall_b),
        .stall_cnt(cnt_b));

    fwd_hazard_unit #(.IDX_W(4), .NREAD(2), .NSTAGE(6), .LOAD_LAT(5), .ZERO_REG_EN(0)) u_c (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_widx(issue_widx), .issue_is_load(issue_is_load), .rd_en(rd_en),
        .rd_idx(rd_idx), .flush(flush), .mux_sel(sel_c), .stall_out(stall_c),
        .stall_cnt(cnt_c));

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_sel(input int c, input int p);
        case (c)
            0:       return int'(sel_a[p*2 +: 2]);
            1:       return int'(sel_b[p*3 +: 3]);
            default: return int'(sel_c[p*3 +: 3]);
        endcase
    endfunction

    function automatic int dut_stall(input int c);
        case (c)
            0:       return int'(stall_a);
            1:       return int'(stall_b);
            default: return int'(stall_c);
        endcase
    endfunction

    function automatic int dut_cnt(input int c);
        case (c)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int cfg;
        int cyc;
        bit we;
        int widx;
        bit ld;
    } rec_t;

    int   cfg_nst [3] = '{2, 3, 6};
    int   cfg_lat [3] = '{1, 2, 5};
    int   cfg_zr  [3] = '{0, 1, 0};

    rec_t hist[$];
    int   now = 0;
    int   last_kill [3] = '{-1, -1, -1};
    int   cnt_m     [3] = '{0, 0, 0};
    bit   exp_stall [3];
    int   exp_sel   [3][2];
    bit   model_on = 1'b1;

    task automatic model_eval();
        for (int c = 0; c < 3; c++) begin
            exp_stall[c] = 1'b0;
            if (rst) cnt_m[c] = 0;
            for (int p = 0; p < 2; p++) begin
                int best;
                bit bld;
                bit haz;
                int idx;
                best = 0;
                bld  = 1'b0;
                idx  = int'(rd_idx[p*4 +: 4]);
                if (!rst && rd_en[p] && !(cfg_zr[c] != 0 && idx == 0)) begin
                    foreach (hist[i]) begin
                        int age;
                        age = now - hist[i].cyc;
                        if (hist[i].cfg == c && hist[i].cyc > last_kill[c] &&
                            age >= 1 && age <= cfg_nst[c] && hist[i].we &&
                            hist[i].widx == idx && (best == 0 || age < best)) begin
                            best = age;
                            bld  = hist[i].ld;
                        end
                    end
                end
                haz = (best != 0) && bld && (best <= cfg_lat[c]);
                exp_sel[c][p] = (best == 0 || haz) ? 1 : best + 1;
                if (haz) exp_stall[c] = 1'b1;
            end
            if (flush) exp_stall[c] = 1'b0;
        end
    endtask

    task automatic model_commit();
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                last_kill[c] = now;
                cnt_m[c]     = 0;
            end else if (flush) begin
                last_kill[c] = now;
            end else begin
                if (exp_stall[c] && cnt_m[c] < 65535) cnt_m[c]++;
                if (issue_valid && !exp_stall[c]) begin
                    hist.push_back('{cfg: c, cyc: now, we: issue_we,
                                     widx: int'(issue_widx), ld: issue_is_load});
                end
            end
        end
        now++;
        while (hist.size() > 0 && hist[0].cyc < now - 8) void'(hist.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Cycle helpers: drive at the falling edge, sample 2 ns later
    // ------------------------------------------------------------------
    task automatic drive(input bit r, input bit iv, input bit we, input bit ld,
                         input int widx, input bit [1:0] en, input int i0,
                         input int i1, input bit fl);
        rst           = r;
        issue_valid   = iv;
        issue_we      = we;
        issue_is_load = ld;
        issue_widx    = 4'(widx);
        rd_en         = en;
        rd_idx        = {4'(i1), 4'(i0)};
        flush         = fl;
    endtask

    task automatic sample();
        #2;
        model_eval();
        if (model_on) begin
            for (int c = 0; c < 3; c++) begin
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("model sel cfg%0d port%0d t%0d", c, p, now),
                          dut_sel(c, p), exp_sel[c][p]);
                end
                check($sformatf("model stall cfg%0d t%0d", c, now), dut_stall(c), int'(exp_stall[c]));
                check($sformatf("model cnt cfg%0d t%0d", c, now), dut_cnt(c), cnt_m[c]);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors for the default configuration
    // ------------------------------------------------------------------
    typedef struct {
        bit       r, iv, we, ld;
        int       widx;
        bit [1:0] en;
        int       i0, i1;
        bit       fl;
        int       s0, s1, st, cnt;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit iv, input bit we, input bit ld,
                                input int widx, input bit [1:0] en, input int i0,
                                input int i1, input bit fl, input int s0,
                                input int s1, input int st, input int cnt);
        vec_t v;
        v.r = r; v.iv = iv; v.we = we; v.ld = ld; v.widx = widx; v.en = en;
        v.i0 = i0; v.i1 = i1; v.fl = fl; v.s0 = s0; v.s1 = s1; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        //             r iv we ld widx en     i0 i1 fl  s0 s1 st cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 2'b11, 3, 3, 0,  1, 1, 0, 0); // reset state
        vecs[1]  = mk(0, 1, 1, 0, 5, 2'b00, 0, 0, 0,  1, 1, 0, 0); // ALU writes 5
        vecs[2]  = mk(0, 0, 0, 0, 0, 2'b01, 5, 0, 0,  2, 1, 0, 0); // stage 1
        vecs[3]  = mk(0, 0, 0, 0, 0, 2'b01, 5, 0, 0,  3, 1, 0, 0); // stage 2
        vecs[4]  = mk(0, 0, 0, 0, 0, 2'b01, 5, 0, 0,  1, 1, 0, 0); // retired
        vecs[5]  = mk(0, 1, 1, 0, 7, 2'b00, 0, 0, 0,  1, 1, 0, 0); // writer 7
        vecs[6]  = mk(0, 1, 1, 0, 7, 2'b10, 0, 7, 0,  1, 2, 0, 0); // writer 7 again
        vecs[7]  = mk(0, 0, 0, 0, 0, 2'b10, 0, 7, 0,  1, 2, 0, 0); // youngest wins
        vecs[8]  = mk(0, 0, 0, 0, 0, 2'b10, 0, 7, 0,  1, 3, 0, 0); // older only
        vecs[9]  = mk(0, 1, 1, 1, 4, 2'b00, 0, 0, 0,  1, 1, 0, 0); // load 4
        vecs[10] = mk(0, 1, 1, 0, 6, 2'b01, 4, 0, 0,  1, 1, 1, 0); // load-use stall
        vecs[11] = mk(0, 1, 1, 0, 6, 2'b01, 4, 0, 0,  3, 1, 0, 1); // consumer issues
        vecs[12] = mk(0, 0, 0, 0, 0, 2'b01, 4, 6, 0,  1, 1, 0, 1); // bubble, port1 off
        vecs[13] = mk(0, 0, 0, 0, 0, 2'b11, 6, 6, 0,  3, 3, 0, 1); // consumer at stage 2
        vecs[14] = mk(0, 1, 1, 1, 2, 2'b00, 0, 0, 0,  1, 1, 0, 1); // load 2
        vecs[15] = mk(0, 1, 1, 0, 8, 2'b01, 2, 0, 1,  1, 1, 0, 1); // flush beats stall
        vecs[16] = mk(0, 0, 0, 0, 0, 2'b11, 2, 8, 0,  1, 1, 0, 1); // all empty
        vecs[17] = mk(0, 0, 0, 0, 0, 2'b11, 2, 8, 0,  1, 1, 0, 1);

        drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].iv, vecs[i].we, vecs[i].ld, vecs[i].widx,
                  vecs[i].en, vecs[i].i0, vecs[i].i1, vecs[i].fl);
            sample();
            check($sformatf("vec%0d sel0", i),  dut_sel(0, 0), vecs[i].s0);
            check($sformatf("vec%0d sel1", i),  dut_sel(0, 1), vecs[i].s1);
            check($sformatf("vec%0d stall", i), int'(stall_a), vecs[i].st);
            check($sformatf("vec%0d cnt", i),   int'(cnt_a),   vecs[i].cnt);
            advance();
        end

        // --------------------------------------------------------------
        // Zero register and two-cycle load latency (configuration b)
        // --------------------------------------------------------------
        drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        sample();
        advance();
        drive(0, 1, 1, 1, 0, 2'b00, 0, 0, 0);          // load to r0
        sample();
        advance();
        drive(0, 1, 1, 0, 3, 2'b01, 0, 0, 0);          // consumer of r0
        sample();
        check("zr r0 sel",   dut_sel(1, 0), 1);
        check("zr r0 stall", int'(stall_b), 0);
        advance();
        drive(0, 1, 1, 1, 9, 2'b00, 0, 0, 0);          // load to r9
        sample();
        advance();
        drive(0, 1, 1, 0, 1, 2'b01, 9, 0, 0);          // consumer of r9
        sample();
        check("lat2 stall1", int'(stall_b), 1);
        check("lat2 sel1",   dut_sel(1, 0), 1);
        advance();
        sample();
        check("lat2 stall2", int'(stall_b), 1);
        check("lat2 cnt2",   int'(cnt_b), 1);
        advance();
        sample();
        check("lat2 release", int'(stall_b), 0);
        check("lat2 sel",     dut_sel(1, 0), 4);
        check("lat2 cnt",     int'(cnt_b), 2);
        advance();

        // --------------------------------------------------------------
        // Random stimulus against the model
        // --------------------------------------------------------------
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)), 2'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 24) == 0);
            sample();
            advance();
        end

        // --------------------------------------------------------------
        // Counter saturation: a self-consuming load stalls configuration c
        // five cycles out of six
        // --------------------------------------------------------------
        drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        sample();
        advance();
        model_on = 1'b0;
        drive(0, 1, 1, 1, 4, 2'b01, 4, 0, 0);
        for (int i = 0; i < 84100; i++) begin
            sample();
            advance();
        end
        model_on = 1'b1;
        sample();
        check("sat cnt", int'(cnt_c), 65535);
        advance();
        sample();
        check("sat hold", int'(cnt_c), 65535);
        advance();

        // Reset clears the saturated counter immediately.
        drive(1, 0, 0, 0, 0, 2'b11, 4, 4, 0);
        sample();
        check("rst cnt",   int'(cnt_c), 0);
        check("rst sel",   dut_sel(2, 0), 1);
        check("rst stall", int'(stall_c), 0);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the in-order pipeline, successor to the fixed 2-port, 2-stage combinational forwarding unit. It tracks destination registers of in-flight instructions in an internal shift pipeline of NSTAGE entries. From that state it produces per-read-port operand mux selects and a load-use stall, and keeps a saturating stall counter. Sits beside decode; selects drive the operand muxes ahead of EX.

## Interface
- IDX_W, 4: register index width.
- NREAD, 2: number of decode read ports.
- NSTAGE, 2: number of tracked forwarding stages; 1..6.
- LOAD_LAT, 1: stages a load occupies before its data is forwardable; 0..NSTAGE-1.
- ZERO_REG_EN, 0: when 1, index 0 never forwards and never stalls.
- SEL_W, derived: clog2(NSTAGE+2).

- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_we  in  1  that instruction writes a register.
- issue_widx  in  IDX_W  its destination index.
- issue_is_load  in  1  that instruction is a load.
- rd_en  in  NREAD  per-port read enable.
- rd_idx  in  NREAD*IDX_W  per-port read index; port p at bits [p*IDX_W +: IDX_W].
- flush  in  1  kill all tracked entries.
- mux_sel  out  NREAD*SEL_W  per-port select: 1 = register file, k+1 = stage k result.
- stall_out  out  1  load-use hazard; decode must hold and not issue.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Entry per stage k (1 = youngest, i.e. EX; NSTAGE = oldest): valid, we, widx, is_load.
- A stage k entry matches port p when: rd_en[p], valid, we, widx == rd_idx[p], and not (ZERO_REG_EN and rd_idx[p] == 0).
- Per port, the youngest matching stage wins.
  - Winner is a load at k <= LOAD_LAT: port hazard; mux_sel = 1.
  - Other winner: mux_sel = k+1.
  - No match: mux_sel = 1.
  - A port with rd_en = 0 always selects 1 and never hazards.
- Select value 0 and values above NSTAGE+1 are never driven.
- stall_out = OR of port hazards, forced 0 while flush is high.
- Shift each cycle, if flush is 0:
  - stage k <= stage k-1 for k >= 2.
  - stage 1 <= issue fields when issue_valid and not stall_out; otherwise a bubble (valid = 0).
- flush = 1: every stage is made invalid next cycle and the issue entry is dropped; flush beats stall.
- stall_cnt increments by 1 on each cycle stall_out is high, holds at 16'hFFFF, and is cleared only by rst.

## Timing
- rst asserted: all entries invalid immediately (asynchronous), stall_cnt = 0; hence mux_sel = all ports 1 and stall_out = 0.
- mux_sel and stall_out are combinational from the registered entries and the current rd_en/rd_idx/flush. They are valid in the same cycle as decode inputs, with no added latency.
- Entry latency: an instruction issued in cycle t is visible at stage 1 in t+1 and at stage k in t+k. It leaves tracking after t+NSTAGE.
- Load-use: a load issued at t, consumed by the next instruction, stalls cycles t+1..t+LOAD_LAT. The consumer issues at t+LOAD_LAT+1 with select LOAD_LAT+2.
- Back-to-back identical widx: the younger stage shadows the older.
- Flush mid-stall: stall_out drops in the same cycle; entries are empty the next cycle.
- Reset mid-operation: takes effect asynchronously, mid-cycle, with no partial shift.

## Test plan
- Reset: rst=1 with rd_en=2'b11, rd_idx={4'd3,4'd3} -> mux_sel={2'd1,2'd1}, stall_out=0, stall_cnt=0.
- Defaults, ALU chain: issue we, widx=5; next cycle rd_idx port0=5 -> sel0=2. One cycle later with no new writer -> sel0=3. Following cycle -> sel0=1.
- Defaults, double writer: widx=7 in stage 1 and stage 2; port1 reads 7 -> sel1=2, because the youngest wins.
- Defaults, load-use: load widx=4, then consumer reads 4 -> stall_out=1 for exactly 1 cycle, stall_cnt=1. Next cycle sel=3 and a bubble is in stage 1.
- ZERO_REG_EN=1, NSTAGE=3, LOAD_LAT=2: load widx=0, consumer reads 0 -> no stall, sel=1. Load widx=9, consumer reads 9 -> 2 stall cycles, then sel=4.
- Flush during a load-use stall -> stall_out=0 that cycle; next cycle all selects = 1. Forcing 70000 stall cycles -> stall_cnt=16'hFFFF.
